ysyx_25040109_lsu: RTL and testbench

- Multi-cycle load/store unit; consumes the effective address, store data and funct3 produced by the execute stage.
- Drives a valid/ready memory request channel and a memory response channel.
- Returns aligned and extended load data, or a store completion, with a writeback handshake.
- Replaces single-cycle combinational memory access; sits between the execute stage and data memory/bus.

---
 rtl/ysyx_25040109_lsu.sv | 166 ++++++++++++++++
 tb/tb_ysyx_25040109_lsu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040109_lsu.sv
// Multi-cycle load/store unit: IDLE->REQ->WAIT->DONE, 3 cycles accept-to-completion with an immediately responding memory.
// Request and completion stall on mem_req_ready/out_ready with every registered output held; rejected ops complete in 1 cycle.
module ysyx_25040109_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd_addr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic [4:0]        out_rd_addr,
    output logic              out_reg_we,
    output logic              out_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic        to_hit;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;
    logic        is_ld_r;
    logic        op_err;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic [31:0] resp_shift;
    logic [31:0] load_ext;

    assign in_ready      = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign out_valid     = (state == DONE);
    assign cnt_inc       = cnt + 8'd1;
    assign to_hit        = (cnt_inc == TO_LIM);

    always_comb begin
        op_err = 1'b0;
        if (is_load == is_store)
            op_err = 1'b1;
        else if (is_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
            op_err = 1'b1;
        else if (is_store && funct3 > 3'b010)
            op_err = 1'b1;
        if (funct3[1:0] == 2'b01 && addr[0])
            op_err = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            op_err = 1'b1;
    end

    // Stores replicate the datum across the word; the mask selects the lane.
    always_comb begin
        lane_wdata = wdata;
        lane_wmask = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                lane_wdata = {4{wdata[7:0]}};
                lane_wmask = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{wdata[15:0]}};
                lane_wmask = 4'b0011 << addr[1:0];
            end
            default: ;
        endcase
    end

    assign resp_shift = mem_resp_data >> {ld_off, 3'b000};

    always_comb begin
        load_ext = resp_shift;
        case (ld_f3)
            3'b000:  load_ext = {{24{resp_shift[7]}}, resp_shift[7:0]};
            3'b100:  load_ext = {24'd0, resp_shift[7:0]};
            3'b001:  load_ext = {{16{resp_shift[15]}}, resp_shift[15:0]};
            3'b101:  load_ext = {16'd0, resp_shift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = op_err ? DONE : REQ;
            REQ:  if (mem_req_ready) state_nx = WAIT;
            WAIT: if (mem_resp_valid || to_hit) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= 8'd0;
            ld_f3         <= 3'd0;
            ld_off        <= 2'd0;
            is_ld_r       <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= 32'd0;
            mem_req_wmask <= 4'd0;
            out_rdata     <= 32'd0;
            out_rd_addr   <= 5'd0;
            out_reg_we    <= 1'b0;
            out_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ld_f3         <= funct3;
                    ld_off        <= addr[1:0];
                    is_ld_r       <= is_load;
                    mem_req_addr  <= {addr[ADDR_W-1:2], 2'b00};
                    mem_req_wen   <= is_store;
                    mem_req_wdata <= is_store ? lane_wdata : 32'd0;
                    mem_req_wmask <= is_store ? lane_wmask : 4'd0;
                    out_rd_addr   <= rd_addr;
                    out_rdata     <= 32'd0;
                    out_reg_we    <= 1'b0;
                    out_err       <= op_err;
                end
                REQ: if (mem_req_ready) cnt <= 8'd0;
                WAIT: begin
                    if (mem_resp_valid) begin
                        out_rdata  <= is_ld_r ? load_ext : 32'd0;
                        out_reg_we <= is_ld_r && (out_rd_addr != 5'd0);
                        out_err    <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                        if (to_hit) out_err <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_rdata  <= 32'd0;
                    out_reg_we <= 1'b0;
                    out_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Directed bench for the LSU: expected requests/completions are queued at issue and checked by memory/writeback monitors.
module tb_ysyx_25040109_lsu;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } exp_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        we;
        logic        err;
    } exp_out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd_addr;
    logic        out_reg_we;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int hs_count = 0;
    int req_stall = 0;
    int out_stall = 0;
    bit resp_en = 1'b1;
    bit hs_next = 1'b0;
    bit stray = 1'b0;
    logic [31:0] resp_word = 32'd0;

    exp_req_t req_q[$];
    exp_out_t out_q[$];

    ysyx_25040109_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rd_addr(rd_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_rd_addr(out_rd_addr),
        .out_reg_we(out_reg_we), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic wen, input logic [31:0] wd, input logic [3:0] wm);
        exp_req_t r;
        r.addr = a; r.wen = wen; r.wdata = wd; r.wmask = wm;
        req_q.push_back(r);
    endtask

    task automatic push_out(input logic [31:0] rdata, input logic [4:0] rd, input logic we, input logic err);
        exp_out_t o;
        o.rdata = rdata; o.rd = rd; o.we = we; o.err = err;
        out_q.push_back(o);
    endtask

    // Memory model: ready after req_stall cycles, one-cycle response in the cycle after the handshake.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (stray) begin
                stray = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'h5555AAAA;
            end else if (hs_next) begin
                hs_next = 1'b0;
                if (resp_en) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = resp_word;
                end
            end
            if (mem_req_valid && !rst) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr 0x%08h, expected no request", mem_req_addr);
                end else begin
                    chk("req_addr", mem_req_addr, req_q[0].addr);
                    chk("req_wen", {31'd0, mem_req_wen}, {31'd0, req_q[0].wen});
                    chk("req_wmask", {28'd0, mem_req_wmask}, {28'd0, req_q[0].wmask});
                    if (req_q[0].wen) chk("req_wdata", mem_req_wdata, req_q[0].wdata);
                end
                if (req_stall > 0) begin
                    req_stall--;
                    mem_req_ready = 1'b0;
                end else begin
                    mem_req_ready = 1'b1;
                    hs_next = 1'b1;
                    hs_count++;
                    if (req_q.size() != 0) void'(req_q.pop_front());
                end
            end else begin
                mem_req_ready = 1'b0;
            end
        end
    end

    // Writeback monitor: compares the head of the completion queue while out_valid is up.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (out_valid && !rst) begin
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got rdata 0x%08h err %0b, expected no completion", out_rdata, out_err);
                    out_ready = 1'b1;
                end else begin
                    chk("out_rdata", out_rdata, out_q[0].rdata);
                    chk("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, out_q[0].rd});
                    chk("out_reg_we", {31'd0, out_reg_we}, {31'd0, out_q[0].we});
                    chk("out_err", {31'd0, out_err}, {31'd0, out_q[0].err});
                    if (out_stall > 0) begin
                        out_stall--;
                        out_ready = 1'b0;
                    end else begin
                        out_ready = 1'b1;
                        void'(out_q.pop_front());
                        done_cnt++;
                    end
                end
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Issue one op at the current negedge; exp_lat counts negedges after the accept edge until out_valid.
    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input int exp_lat);
        int target;
        int lat;
        int n;
        target = done_cnt + 1;
        is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd; rd_addr = rd;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 400) begin @(negedge clk); lat++; end
        chk("latency", lat, exp_lat);
        n = 0;
        while (done_cnt < target && n < 50) begin @(negedge clk); n++; end
        chk("completion", done_cnt, target);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        bit seen;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // LW
        resp_word = 32'hDEADBEEF;
        push_req(32'h80000004, 1'b0, 32'd0, 4'b0000);
        push_out(32'hDEADBEEF, 5'd5, 1'b1, 1'b0);
        do_op(1'b1, 1'b0, 3'b010, 32'h80000004, 32'd0, 5'd5, 3);

        // Byte/halfword extraction and extension
        resp_word = 32'h80FF1234;
        push_req(32'h80000000, 1'b0, 32'd0, 4'b0000);
        push_out(32'hFFFFFF80, 5'd6, 1'b1, 1'b0);
        do_op(1'b1, 1'b0, 3'b000, 32'h80000003, 32'd0, 5'd6, 3);
        push_req(32'h80000000, 1'b0, 32'd0, 4'b0000);
        push_out(32'h00000080, 5'd7, 1'b1, 1'b0);
        do_op(1'b1, 1'b0, 3'b100, 32'h80000003, 32'd0, 5'd7, 3);
        push_req(32'h80000000, 1'b0, 32'd0, 4'b0000);
        push_out(32'h000080FF, 5'd8, 1'b1, 1'b0);
        do_op(1'b1, 1'b0, 3'b101, 32'h80000002, 32'd0, 5'd8, 3);
        push_req(32'h80000000, 1'b0, 32'd0, 4'b0000);
        push_out(32'hFFFF80FF, 5'd9, 1'b1, 1'b0);
        do_op(1'b1, 1'b0, 3'b001, 32'h80000002, 32'd0, 5'd9, 3);

        // rd = 0 never writes back
        resp_word = 32'h11223344;
        push_req(32'h80000010, 1'b0, 32'd0, 4'b0000);
        push_out(32'h11223344, 5'd0, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 3'b010, 32'h80000010, 32'd0, 5'd0, 3);

        // Stores
        resp_word = 32'h0;
        push_req(32'h80000000, 1'b1, 32'hABCDABCD, 4'b1100);
        push_out(32'd0, 5'd9, 1'b0, 1'b0);
        do_op(1'b0, 1'b1, 3'b001, 32'h80000002, 32'h0000ABCD, 5'd9, 3);
        push_req(32'h80000000, 1'b1, 32'h78787878, 4'b0010);
        push_out(32'd0, 5'd3, 1'b0, 1'b0);
        do_op(1'b0, 1'b1, 3'b000, 32'h80000001, 32'h12345678, 5'd3, 3);
        push_req(32'h8000000C, 1'b1, 32'hCAFEBABE, 4'b1111);
        push_out(32'd0, 5'd4, 1'b0, 1'b0);
        do_op(1'b0, 1'b1, 3'b010, 32'h8000000C, 32'hCAFEBABE, 5'd4, 3);

        // Rejected ops: no request, completion one cycle after accept
        hs0 = hs_count;
        push_out(32'd0, 5'd5, 1'b0, 1'b1);
        do_op(1'b1, 1'b0, 3'b010, 32'h80000001, 32'd0, 5'd5, 1);
        push_out(32'd0, 5'd6, 1'b0, 1'b1);
        do_op(1'b0, 1'b1, 3'b001, 32'h80000001, 32'h1, 5'd6, 1);
        push_out(32'd0, 5'd7, 1'b0, 1'b1);
        do_op(1'b1, 1'b1, 3'b010, 32'h80000004, 32'd0, 5'd7, 1);
        push_out(32'd0, 5'd8, 1'b0, 1'b1);
        do_op(1'b1, 1'b0, 3'b011, 32'h80000000, 32'd0, 5'd8, 1);
        push_out(32'd0, 5'd9, 1'b0, 1'b1);
        do_op(1'b0, 1'b1, 3'b100, 32'h80000000, 32'd0, 5'd9, 1);
        chk("err_no_requests", hs_count, hs0);

        // Back-pressure on both sides
        hs0 = hs_count;
        resp_word = 32'h0BADF00D;
        req_stall = 4;
        out_stall = 3;
        push_req(32'h80000008, 1'b0, 32'd0, 4'b0000);
        push_out(32'h0BADF00D, 5'd7, 1'b1, 1'b0);
        do_op(1'b1, 1'b0, 3'b010, 32'h80000008, 32'd0, 5'd7, 7);
        chk("stall_one_request", hs_count, hs0 + 1);

        // Timeout: 255 WAIT cycles, then an error completion
        resp_en = 1'b0;
        push_req(32'h80000020, 1'b0, 32'd0, 4'b0000);
        push_out(32'd0, 5'd12, 1'b0, 1'b1);
        do_op(1'b1, 1'b0, 3'b010, 32'h80000020, 32'd0, 5'd12, 257);

        // Reset while in WAIT
        push_req(32'h80000030, 1'b0, 32'd0, 4'b0000);
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80000030; rd_addr = 5'd2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        resp_en = 1'b1;
        stray = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("stray_resp_no_out", {31'd0, seen}, 32'd0);
        chk("stray_in_ready", {31'd0, in_ready}, 32'd1);
        chk("req_queue_drained", req_q.size(), 0);
        chk("out_queue_drained", out_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
